robo: RTL and testbench

- Control FSM for a grid-maze robot that follows a wall on its left.
- Each move slot it reads two obstacle sensors, `head` (cell ahead) and `left` (cell to the robot's left).
- It then commands exactly one action: advance one cell (`avancar`) or rotate 90° counter-clockwise in place (`girar`, N→W→S→E→N).
- It sits between the sensor front-end and the motion actuator. The environment updates the robot position between move slots.

---
 rtl/robo.sv | 71 +++++++
 tb/tb_robo.sv | 129 ++++++++++++
 2 files changed

// File: rtl/robo.sv
// robo: left-wall-following maze robot control FSM
module robo (
  input  logic clock,
  input  logic reset,
  input  logic head,
  input  logic left,
  output logic avancar,
  output logic girar
);
  typedef enum logic [2:0] {
    SEARCH = 3'd0,
    FOLLOW = 3'd1,
    TURNED = 3'd2,
    RIGHT1 = 3'd3,
    RIGHT2 = 3'd4
  } state_t;
  state_t state, nxt, f_st;
  logic   decide, av_n, gi_n, f_av;
  // Alternate DECIDE/IDLE edges; commands and state advance only on DECIDE edges
  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= SEARCH;
      decide  <= 1'b1;
      avancar <= 1'b0;
      girar   <= 1'b0;
    end else if (decide) begin
      state   <= nxt;
      decide  <= 1'b0;
      avancar <= av_n;
      girar   <= gi_n;
    end else begin
      decide  <= 1'b1;
      avancar <= 1'b0;
      girar   <= 1'b0;
    end
  end
  // Next-state and command decode; a right turn is three CCW rotations via RIGHT1/RIGHT2
  always_comb begin
    f_av = left & ~head;
    f_st = !left ? TURNED : head ? RIGHT1 : FOLLOW;
    nxt  = SEARCH;
    av_n = 1'b0;
    gi_n = 1'b0;
    case (state)
      SEARCH: begin
        av_n = ~head;
        gi_n = head;
        nxt  = head ? RIGHT1 : left ? FOLLOW : SEARCH;
      end
      FOLLOW: begin
        av_n = f_av;
        gi_n = ~f_av;
        nxt  = f_st;
      end
      TURNED: begin
        av_n = ~head;
        gi_n = head;
        nxt  = !head ? FOLLOW : f_st;
      end
      RIGHT1: begin
        gi_n = 1'b1;
        nxt  = RIGHT2;
      end
      RIGHT2: begin
        gi_n = 1'b1;
        nxt  = FOLLOW;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_robo.sv
// tb_robo: scoreboard bench for the wall-following robot FSM
module tb_robo;
  logic clock, reset, head, left, avancar, girar;
  int checks = 0;
  int errors = 0;
  int ms;
  typedef struct {
    logic [1:0] exp;
    string      name;
  } item_t;
  item_t q[$];

  robo dut (
    .clock(clock),
    .reset(reset),
    .head(head),
    .left(left),
    .avancar(avancar),
    .girar(girar)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  // Drive one edge's inputs at the negedge and queue the {avancar,girar} expected after it
  task automatic step(input logic r, input logic h, input logic l, input logic [1:0] e, input string n);
    @(negedge clock);
    reset = r;
    head  = h;
    left  = l;
    q.push_back('{e, n});
  endtask

  // Reference model of one DECIDE edge written from the behavioural rules
  task automatic model(input logic h, input logic l, output logic [1:0] e);
    if (ms == 0 && l) ms = 1;
    if (ms == 2 && h) ms = 1;
    case (ms)
      0: if (!h) e = 2'b10; else begin e = 2'b01; ms = 3; end
      1: if (!l) begin e = 2'b01; ms = 2; end
         else if (!h) e = 2'b10;
         else begin e = 2'b01; ms = 3; end
      2: begin e = 2'b10; ms = 1; end
      3: begin e = 2'b01; ms = 4; end
      4: begin e = 2'b01; ms = 1; end
      default: begin e = 2'b00; ms = 0; end
    endcase
  endtask

  // Monitor: every edge is an output event; pop the expectation and compare
  always @(posedge clock) begin
    #1;
    if (q.size() != 0) begin
      item_t it;
      it = q.pop_front();
      checks++;
      if ({avancar, girar} !== it.exp) begin
        errors++;
        $display("FAIL %s: got avancar,girar=%b required %b", it.name, {avancar, girar}, it.exp);
      end
    end
  end

  initial begin
    logic [1:0] e;
    reset = 0;
    head  = 0;
    left  = 0;
    // 1: reset then first DECIDE edge
    step(0, 0, 0, 2'b00, "reset0");
    step(0, 0, 0, 2'b00, "reset1");
    step(1, 0, 0, 2'b10, "first_decide");
    step(1, 0, 0, 2'b00, "first_idle");
    // 2: SEARCH advancing, then head blocked starts a right turn
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 2'b10, "search_adv");
      step(1, 1, 1, 2'b00, "search_idle");
    end
    step(1, 1, 0, 2'b01, "search_block");
    step(1, 0, 0, 2'b00, "idle");
    step(1, 1'($urandom), 1'($urandom), 2'b01, "right1");
    step(1, 0, 0, 2'b00, "idle");
    step(1, 1'($urandom), 1'($urandom), 2'b01, "right2");
    step(1, 0, 0, 2'b00, "idle");
    step(1, 0, 1, 2'b10, "follow_adv");
    step(1, 0, 0, 2'b00, "idle");
    // 3: FOLLOW, wall ends, forced advance after a left turn
    step(1, 0, 1, 2'b10, "follow_adv2");
    step(1, 0, 0, 2'b00, "idle");
    step(1, 1, 0, 2'b01, "follow_gap");
    step(1, 0, 0, 2'b00, "idle");
    step(1, 0, 0, 2'b10, "turned_adv");
    step(1, 0, 0, 2'b00, "idle");
    step(1, 0, 0, 2'b01, "follow_gap2");
    step(1, 0, 0, 2'b00, "idle");
    // 4: enclosed cell
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 1, 2'b01, "enclosed");
      step(1, 1, 1, 2'b00, "enclosed_idle");
    end
    // 5: reset aborts a pending right turn
    step(0, 0, 0, 2'b00, "reset_a");
    step(1, 1, 0, 2'b01, "enter_right1");
    step(0, 0, 0, 2'b00, "reset_mid");
    step(1, 0, 0, 2'b10, "after_abort");
    step(1, 0, 0, 2'b00, "idle");
    // 6: random sensors against the reference model
    step(0, 0, 0, 2'b00, "reset_b");
    ms = 0;
    for (int i = 0; i < 200; i++) begin
      logic h, l;
      h = 1'($urandom);
      l = 1'($urandom);
      model(h, l, e);
      step(1, h, l, e, "rand_decide");
      step(1, 1'($urandom), 1'($urandom), 2'b00, "rand_idle");
    end
    repeat (3) @(negedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
